block_program_loader: RTL and testbench
=======================================

Name: block_program_loader

Overview:
- Writer side of the block instruction memory and the block register file that the fetch/decode stage reads.
- Takes a byte-serial command stream from the host-interface side (valid/ready), assembles complete commands, and issues single-cycle writes to the instruction RAM and the register RAM.
- Drives the program-extent outputs n_blocks_running and last_block, plus a one-cycle invalidate_reg_read pulse, so the fetch stage stays coherent with live edits.

Parameters:
data_width, 16, block register width; must be 16 (two payload bytes).
n_blocks, 256, instruction/register slots; must be ≤256 (one address byte).
n_block_regs, 2, registers per block; must be ≤256 (one register-select byte).
timeout_cycles, 65535, idle cycles tolerated mid-command before abort; must be ≥1.

Ports:
clk  in  1  clock
reset  in  1  synchronous, active-high
in_valid  in  1  command byte present
in_ready  out  1  byte accepted when in_valid && in_ready
in_data  in  8  command byte
instr_write_en  out  1  one-cycle instruction RAM write strobe
instr_write_addr  out  clog2(n_blocks)  block index
instr_write_val  out  32  instruction word
reg_write_en  out  1  one-cycle register RAM write strobe
reg_write_addr  out  clog2(n_blocks)  block index
reg_write_sel  out  clog2(n_block_regs) (min 1)  register index
reg_write_val  out  data_width  register value
n_blocks_running  out  clog2(n_blocks)  active block count; 0 = halted
last_block  out  clog2(n_blocks)  highest active block index
invalidate_reg_read  out  1  one-cycle pulse after any register write
busy  out  1  high whenever the state is not IDLE
error  out  1  sticky; cleared by reset or by a CLEAR_ERR command

Behaviour:
- Reset values:
  - All write strobes, write address/value/select outputs, invalidate_reg_read, busy, error and n_blocks_running are 0.
  - last_block resets to 0. The state is IDLE.
  - Reset mid-command discards the partial command; no write is issued.
- Opcodes (first byte of each command):
  - 0x01 WR_INSTR: addr, then b0..b3; instr_write_val = {b3,b2,b1,b0}.
  - 0x02 WR_REG: addr, sel, then lo, hi; reg_write_val = {hi,lo}.
  - 0x03 SET_COUNT: count byte c.
    - n_blocks_running <= c.
    - last_block <= c-1 when c>0; when c=0, last_block keeps its old value.
  - 0x04 HALT: n_blocks_running <= 0.
  - 0x05 CLEAR_ERR: error <= 0.
  - Any other opcode: error <= 1, the byte is consumed, the state stays IDLE.
- Address and select bits above the required width are discarded.
  - WR_INSTR/WR_REG with addr ≥ n_blocks: error <= 1, the payload is consumed, no write is issued.
  - WR_REG with sel ≥ n_block_regs: same handling.
  - SET_COUNT with c > n_blocks: error <= 1, the count outputs are unchanged.
- States: IDLE → ADDR → [SEL] → PAYLOAD (byte counter 0..3 or 0..1) → EXEC → IDLE.
  - SET_COUNT goes IDLE → ARG → EXEC.
  - HALT and CLEAR_ERR go IDLE → EXEC.
- in_ready is 1 in every state except EXEC; one byte is accepted per cycle.
- EXEC lasts exactly one cycle:
  - The strobe (if any) is asserted for that cycle only.
  - Address and value hold their values until the next write.
  - Latency: strobe 1 cycle after the last byte handshake. Throughput: 7 cycles per WR_INSTR.
- invalidate_reg_read pulses for one cycle in the cycle after the reg_write_en cycle. This ensures a reader re-samples the updated value.
- SET_COUNT and HALT update the count outputs in the EXEC cycle and hold them until the next such command.
- Timeout:
  - In any non-IDLE, non-EXEC state, a counter increments each cycle without a handshake and clears on each handshake.
  - At timeout_cycles: abort to IDLE, error <= 1, no write is issued.
  - A handshake in the same cycle as expiry wins and the command continues.
- Simultaneous events: error being set by a command and CLEAR_ERR cannot coincide, because EXEC is serialised.

Decomposition:
- Shared package/header (alongside instr_dec.vh / core.vh): opcode constants LOADER_OP_WR_INSTR..LOADER_OP_CLEAR_ERR, state encodings, payload byte counts per opcode.
- One natural sub-module: loader_byte_assembler (shift register plus byte counter that packs LE bytes into 32 bits). The FSM, range checks and timeout stay in the top module.

Test Plan:
- After reset, stream 01 05 EF BE AD DE → instr_write_en high for exactly 1 cycle, addr=5, val=0xDEADBEEF, error=0.
- Stream 02 03 01 34 12 → reg_write_en with addr=3, sel=1, val=0x1234; invalidate_reg_read pulses the next cycle.
- Send 03 08, then 04 → n_blocks_running=8 and last_block=7; after HALT, n_blocks_running=0 and last_block stays 7.
- Opcode 0x7F, then 02 00 02 00 00 (sel ≥2) → error=1 and no strobes; then 05 → error=0.
- Set timeout_cycles=10, send 01 05 AA, then hold in_valid low for 10 cycles → state IDLE, error=1, no write; the following 01 00 01 00 00 00 writes val=0x00000001.
- Random in_valid gaps under timeout, plus reset asserted midway through a WR_INSTR payload → no partial write; the next full command is written correctly.

Source files
------------

// File: rtl/block_program_loader_pkg.sv
// block_program_loader_pkg: opcodes, FSM states and payload lengths shared by the program loader
package block_program_loader_pkg;

    localparam logic [7:0] LOADER_OP_WR_INSTR  = 8'h01;
    localparam logic [7:0] LOADER_OP_WR_REG    = 8'h02;
    localparam logic [7:0] LOADER_OP_SET_COUNT = 8'h03;
    localparam logic [7:0] LOADER_OP_HALT      = 8'h04;
    localparam logic [7:0] LOADER_OP_CLEAR_ERR = 8'h05;

    typedef enum logic [2:0] {
        S_IDLE,
        S_ADDR,
        S_SEL,
        S_ARG,
        S_PAYLOAD,
        S_EXEC
    } loader_state_t;

    // Index of the final payload byte: WR_INSTR carries 4 bytes, WR_REG carries 2
    function automatic logic [1:0] payload_last(input logic [7:0] op);
        return op == LOADER_OP_WR_INSTR ? 2'd3 : 2'd1;
    endfunction

endpackage

// File: rtl/block_program_loader_byte_assembler.sv
// block_program_loader_byte_assembler: packs little-endian payload bytes into a 32-bit word
//   clk, reset  : clock, synchronous active-high reset
//   clear       : restart the byte counter (held while not receiving payload)
//   shift_en    : accept byte_in this cycle
//   byte_in     : payload byte
//   word        : assembled word; first byte ends up in [7:0] after four shifts,
//                 and a two-byte payload sits in [31:16]
//   count       : number of payload bytes accepted so far
module block_program_loader_byte_assembler (
    input  logic        clk,
    input  logic        reset,
    input  logic        clear,
    input  logic        shift_en,
    input  logic [7:0]  byte_in,
    output logic [31:0] word,
    output logic [1:0]  count
);

    always_ff @(posedge clk) begin
        if (reset) begin
            word  <= '0;
            count <= '0;
        end else begin
            if (shift_en) word <= {byte_in, word[31:8]};
            count <= clear ? 2'd0 : shift_en ? count + 2'd1 : count;
        end
    end

endmodule

// File: rtl/block_program_loader.sv
// block_program_loader: assembles byte-serial commands and writes the block instruction/register RAMs
//   clk, reset            : clock, synchronous active-high reset
//   in_valid/in_ready     : command byte handshake, in_data is the byte
//   instr_write_*         : single-cycle instruction RAM write (en/addr/val)
//   reg_write_*           : single-cycle register RAM write (en/addr/sel/val)
//   n_blocks_running      : active block count, 0 = halted
//   last_block            : highest active block index
//   invalidate_reg_read   : pulse in the cycle after a register write
//   busy                  : command in progress
//   error                 : sticky error, cleared by reset or CLEAR_ERR
module block_program_loader
    import block_program_loader_pkg::*;
#(
    parameter  int data_width     = 16,
    parameter  int n_blocks       = 256,
    parameter  int n_block_regs   = 2,
    parameter  int timeout_cycles = 65535,
    localparam int aw = n_blocks > 1 ? $clog2(n_blocks) : 1,
    localparam int sw = n_block_regs > 1 ? $clog2(n_block_regs) : 1
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [7:0]            in_data,
    output logic                  instr_write_en,
    output logic [aw-1:0]         instr_write_addr,
    output logic [31:0]           instr_write_val,
    output logic                  reg_write_en,
    output logic [aw-1:0]         reg_write_addr,
    output logic [sw-1:0]         reg_write_sel,
    output logic [data_width-1:0] reg_write_val,
    output logic [aw-1:0]         n_blocks_running,
    output logic [aw-1:0]         last_block,
    output logic                  invalidate_reg_read,
    output logic                  busy,
    output logic                  error
);

    localparam int tw = $clog2(timeout_cycles + 1);

    loader_state_t         state, state_n;
    logic [7:0]            op, addr_b, sel_b, arg;
    logic [tw-1:0]         tmo;
    logic [31:0]           word;
    logic [1:0]            count;
    logic [aw-1:0]         ia_q, ra_q;
    logic [31:0]           iv_q;
    logic [sw-1:0]         rs_q;
    logic [data_width-1:0] rv_q;
    logic                  hs, exec, waiting, expire, known_op, bad_op;
    logic                  addr_ok, sel_ok, cnt_ok, bad_cmd;

    assign in_ready = state != S_EXEC;
    assign hs       = in_valid && in_ready;
    assign busy     = state != S_IDLE;
    assign exec     = state == S_EXEC;
    assign waiting  = busy && !exec;
    // A handshake in the expiry cycle keeps the command alive
    assign expire   = waiting && !hs && tmo == tw'(timeout_cycles - 1);
    assign known_op = in_data inside {[LOADER_OP_WR_INSTR:LOADER_OP_CLEAR_ERR]};
    assign bad_op   = state == S_IDLE && hs && !known_op;

    // Range checks use the full byte; only then are high bits dropped
    assign addr_ok = 32'(addr_b) < n_blocks;
    assign sel_ok  = 32'(sel_b) < n_block_regs;
    assign cnt_ok  = 32'(arg) <= n_blocks;
    assign bad_cmd = (op == LOADER_OP_WR_INSTR && !addr_ok) ||
                     (op == LOADER_OP_WR_REG && !(addr_ok && sel_ok)) ||
                     (op == LOADER_OP_SET_COUNT && !cnt_ok);

    // Strobes are live during EXEC; address/value show the new write then and hold afterwards
    assign instr_write_en   = exec && op == LOADER_OP_WR_INSTR && addr_ok;
    assign reg_write_en     = exec && op == LOADER_OP_WR_REG && addr_ok && sel_ok;
    assign instr_write_addr = instr_write_en ? addr_b[aw-1:0] : ia_q;
    assign instr_write_val  = instr_write_en ? word : iv_q;
    assign reg_write_addr   = reg_write_en ? addr_b[aw-1:0] : ra_q;
    assign reg_write_sel    = reg_write_en ? sel_b[sw-1:0] : rs_q;
    assign reg_write_val    = reg_write_en ? word[31 -: data_width] : rv_q;

    block_program_loader_byte_assembler u_asm (
        .clk      (clk),
        .reset    (reset),
        .clear    (state != S_PAYLOAD),
        .shift_en (state == S_PAYLOAD && hs),
        .byte_in  (in_data),
        .word     (word),
        .count    (count)
    );

    always_comb begin
        state_n = state;
        case (state)
            S_IDLE:    if (hs) state_n = in_data inside {LOADER_OP_WR_INSTR, LOADER_OP_WR_REG} ? S_ADDR :
                                         in_data == LOADER_OP_SET_COUNT ? S_ARG :
                                         known_op ? S_EXEC : S_IDLE;
            S_ADDR:    if (hs) state_n = op == LOADER_OP_WR_REG ? S_SEL : S_PAYLOAD;
            S_SEL:     if (hs) state_n = S_PAYLOAD;
            S_ARG:     if (hs) state_n = S_EXEC;
            S_PAYLOAD: if (hs && count == payload_last(op)) state_n = S_EXEC;
            default:   state_n = S_IDLE;
        endcase
        if (expire) state_n = S_IDLE;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state               <= S_IDLE;
            op                  <= '0;
            addr_b              <= '0;
            sel_b               <= '0;
            arg                 <= '0;
            tmo                 <= '0;
            ia_q                <= '0;
            iv_q                <= '0;
            ra_q                <= '0;
            rs_q                <= '0;
            rv_q                <= '0;
            n_blocks_running    <= '0;
            last_block          <= '0;
            invalidate_reg_read <= 1'b0;
            error               <= 1'b0;
        end else begin
            state <= state_n;
            tmo   <= (hs || !waiting) ? '0 : tmo + tw'(1);
            if (state == S_IDLE && hs) op <= in_data;
            if (state == S_ADDR && hs) addr_b <= in_data;
            if (state == S_SEL && hs) sel_b <= in_data;
            if (state == S_ARG && hs) arg <= in_data;
            if (instr_write_en) begin
                ia_q <= instr_write_addr;
                iv_q <= instr_write_val;
            end
            if (reg_write_en) begin
                ra_q <= reg_write_addr;
                rs_q <= reg_write_sel;
                rv_q <= reg_write_val;
            end
            invalidate_reg_read <= reg_write_en;
            if (exec && op == LOADER_OP_SET_COUNT && cnt_ok) begin
                n_blocks_running <= aw'(arg);
                if (arg != 8'd0) last_block <= aw'(arg - 8'd1);
            end
            if (exec && op == LOADER_OP_HALT) n_blocks_running <= '0;
            error <= (exec && op == LOADER_OP_CLEAR_ERR) ? 1'b0 :
                     (bad_op || expire || (exec && bad_cmd)) ? 1'b1 : error;
        end
    end

endmodule

// File: tb/tb_block_program_loader.sv
// tb_block_program_loader: scoreboard bench for the block program loader with a command-level model
module tb_block_program_loader;

    localparam int NB = 12;
    localparam int NR = 2;
    localparam int TMO = 10;

    logic        clk = 1'b0;
    logic        reset;
    logic        in_valid;
    logic        in_ready;
    logic [7:0]  in_data;
    logic        instr_write_en;
    logic [3:0]  instr_write_addr;
    logic [31:0] instr_write_val;
    logic        reg_write_en;
    logic [3:0]  reg_write_addr;
    logic [0:0]  reg_write_sel;
    logic [15:0] reg_write_val;
    logic [3:0]  n_blocks_running;
    logic [3:0]  last_block;
    logic        invalidate_reg_read;
    logic        busy;
    logic        error;

    block_program_loader #(
        .data_width(16), .n_blocks(NB), .n_block_regs(NR), .timeout_cycles(TMO)
    ) dut (
        .clk                 (clk),
        .reset               (reset),
        .in_valid            (in_valid),
        .in_ready            (in_ready),
        .in_data             (in_data),
        .instr_write_en      (instr_write_en),
        .instr_write_addr    (instr_write_addr),
        .instr_write_val     (instr_write_val),
        .reg_write_en        (reg_write_en),
        .reg_write_addr      (reg_write_addr),
        .reg_write_sel       (reg_write_sel),
        .reg_write_val       (reg_write_val),
        .n_blocks_running    (n_blocks_running),
        .last_block          (last_block),
        .invalidate_reg_read (invalidate_reg_read),
        .busy                (busy),
        .error               (error)
    );

    always #5 clk = ~clk;

    typedef struct { int addr; logic [31:0] val; } iw_t;
    typedef struct { int addr; int sel; logic [15:0] val; } rw_t;

    iw_t        iq[$];
    rw_t        rq[$];
    logic [7:0] cq[$];
    int         m_run, m_last;
    bit         m_err;
    int         vectors = 0;
    int         miscompares = 0;

    function automatic void chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endfunction

    task automatic gap(input int k);
        repeat (k) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic send_byte(input logic [7:0] b);
        int n;
        n = 0;
        in_valid = 1'b1;
        in_data  = b;
        while (!in_ready && n < 50) begin
            @(posedge clk);
            #1;
            n++;
        end
        if (n >= 50) chk("ready_wait_expired", 32'd0, 32'd1);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic check_status(input string nm);
        chk({nm, "_busy"}, busy, 0);
        chk({nm, "_error"}, error, m_err);
        chk({nm, "_running"}, n_blocks_running, m_run);
        chk({nm, "_last"}, last_block, m_last);
    endtask

    // Model works on whole commands: decide the effect first, then stream the bytes
    task automatic run_cmd(input int gmax);
        logic [7:0] op;
        bit wi, wr;
        op = cq[0];
        wi = 0;
        wr = 0;
        case (op)
            8'h01: if (int'(cq[1]) < NB) begin
                       iq.push_back(iw_t'{int'(cq[1]), {cq[5], cq[4], cq[3], cq[2]}});
                       wi = 1;
                   end else m_err = 1;
            8'h02: if (int'(cq[1]) < NB && int'(cq[2]) < NR) begin
                       rq.push_back(rw_t'{int'(cq[1]), int'(cq[2]), {cq[4], cq[3]}});
                       wr = 1;
                   end else m_err = 1;
            8'h03: if (int'(cq[1]) > NB) m_err = 1;
                   else begin
                       m_run = int'(cq[1]);
                       if (cq[1] != 0) m_last = int'(cq[1]) - 1;
                   end
            8'h04: m_run = 0;
            8'h05: m_err = 0;
            default: m_err = 1;
        endcase
        foreach (cq[i]) begin
            if (i > 0 && gmax > 0) gap($urandom_range(0, gmax));
            send_byte(cq[i]);
        end
        if (op >= 8'h01 && op <= 8'h05) begin
            chk("exec_busy", busy, 1);
            chk("exec_ready", in_ready, 0);
            chk("exec_instr_strobe", instr_write_en, wi);
            chk("exec_reg_strobe", reg_write_en, wr);
        end
        @(posedge clk);
        #1;
        chk("invalidate", invalidate_reg_read, wr);
        chk("strobes_off", {30'd0, instr_write_en, reg_write_en}, 0);
        check_status("after_cmd");
    endtask

    // Monitor: every strobe must match the oldest outstanding expected write
    always @(negedge clk) begin
        iw_t ie;
        rw_t re;
        if (!reset) begin
            if (instr_write_en) begin
                if (iq.size() == 0) chk("instr_unexpected", 1, 0);
                else begin
                    ie = iq.pop_front();
                    chk("instr_addr", instr_write_addr, ie.addr);
                    chk("instr_val", instr_write_val, ie.val);
                end
            end
            if (reg_write_en) begin
                if (rq.size() == 0) chk("reg_unexpected", 1, 0);
                else begin
                    re = rq.pop_front();
                    chk("reg_addr", reg_write_addr, re.addr);
                    chk("reg_sel", reg_write_sel, re.sel);
                    chk("reg_val", reg_write_val, re.val);
                end
            end
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int k, a, s;
        logic [31:0] d;
        reset    = 1'b1;
        in_valid = 1'b0;
        in_data  = 8'h00;
        m_run    = 0;
        m_last   = 0;
        m_err    = 0;
        gap(3);
        chk("rst_instr_en", instr_write_en, 0);
        chk("rst_reg_en", reg_write_en, 0);
        chk("rst_instr_addr", instr_write_addr, 0);
        chk("rst_instr_val", instr_write_val, 0);
        chk("rst_reg_val", reg_write_val, 0);
        chk("rst_invalidate", invalidate_reg_read, 0);
        check_status("rst");
        reset = 1'b0;
        gap(1);

        cq = '{8'h01, 8'h05, 8'hEF, 8'hBE, 8'hAD, 8'hDE};
        run_cmd(0);
        cq = '{8'h02, 8'h03, 8'h01, 8'h34, 8'h12};
        run_cmd(0);
        cq = '{8'h03, 8'h08};
        run_cmd(0);
        cq = '{8'h04};
        run_cmd(0);
        cq = '{8'h7F};
        run_cmd(0);
        cq = '{8'h02, 8'h00, 8'h02, 8'h00, 8'h00};
        run_cmd(0);
        cq = '{8'h05};
        run_cmd(0);

        cq = '{8'h01, 8'h0C, 8'h11, 8'h22, 8'h33, 8'h44};
        run_cmd(0);
        cq = '{8'h01, 8'h0B, 8'h11, 8'h22, 8'h33, 8'h44};
        run_cmd(0);
        cq = '{8'h03, 8'h0C};
        run_cmd(0);
        cq = '{8'h03, 8'h0D};
        run_cmd(0);
        cq = '{8'h03, 8'h00};
        run_cmd(0);
        cq = '{8'h05};
        run_cmd(0);

        send_byte(8'h01);
        send_byte(8'h05);
        send_byte(8'hAA);
        gap(TMO - 1);
        chk("tmo_still_busy", busy, 1);
        gap(1);
        m_err = 1;
        check_status("tmo_abort");
        cq = '{8'h01, 8'h00, 8'h01, 8'h00, 8'h00, 8'h00};
        run_cmd(0);
        cq = '{8'h05};
        run_cmd(0);

        for (int n = 0; n < 200; n++) begin
            if (n == 100) begin
                send_byte(8'h01);
                send_byte(8'h05);
                send_byte(8'hAA);
                send_byte(8'hBB);
                reset = 1'b1;
                gap(1);
                reset = 1'b0;
                m_run = 0;
                m_last = 0;
                m_err = 0;
                check_status("mid_reset");
            end
            k = $urandom_range(0, 6);
            a = $urandom_range(0, NB + 2);
            s = $urandom_range(0, 2);
            d = $urandom;
            case (k)
                0: cq = '{8'h01, 8'(a), d[7:0], d[15:8], d[23:16], d[31:24]};
                1: cq = '{8'h02, 8'(a), 8'(s), d[7:0], d[15:8]};
                2: cq = '{8'h03, 8'(a)};
                3: cq = '{8'h04};
                4: cq = '{8'h05};
                default: cq = '{8'h06 + 8'(d[3:0])};
            endcase
            run_cmd(TMO - 1);
        end

        gap(2);
        chk("instr_queue_drained", iq.size(), 0);
        chk("reg_queue_drained", rq.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
